// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and sizing helpers for the UART transmit arbiter.
// The arbiter and its round-robin picker both import this package.
package uart_tx_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOAD       = 3'd1,
    ST_STROBE     = 3'd2,
    ST_WAIT_START = 3'd3,
    ST_WAIT_DONE  = 3'd4,
    ST_GAP        = 3'd5
  } state_t;

  localparam int DEF_NUM_REQ       = 4;
  localparam int DEF_GAP_CYCLES    = 16;
  localparam int DEF_START_TIMEOUT = 15;

  // Width of a requester index; at least one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // One counter serves both the start timeout and the inter-frame gap.
  function automatic int cnt_width(input int gap, input int timeout);
    int m;
    m = (gap > timeout) ? gap : timeout;
    return (m > 1) ? $clog2(m + 1) : 1;
  endfunction

  // Index of the set bit of a one-hot vector; zero for an all-zero vector.
  function automatic int onehot_idx(input logic [7:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < 8; i++) begin
      idx = oh[i] ? i : idx;
    end
    return idx;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester set, searching upward
// from the one after last_grant and wrapping around.
module uart_tx_arbiter_rr_pick
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = idx_width(DEF_NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant
);

  logic [IDX_W-1:0] idx;
  logic             found;
  logic             hit;

  // Priority scan; the last granted requester is visited last.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    hit   = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx        = IDX_W'((int'(last_grant) + off) % NUM_REQ);
      hit        = !found && req[idx];
      grant[idx] = grant[idx] | hit;
      found      = found | hit;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates several byte-stream requesters onto one UART transmitter,
// holding ownership for a whole frame and spacing frames by an idle gap.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ       = DEF_NUM_REQ,
  parameter int GAP_CYCLES    = DEF_GAP_CYCLES,
  parameter int START_TIMEOUT = DEF_START_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_wr,
  input  logic                 tx_idle,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy
);

  localparam int IDX_W = idx_width(NUM_REQ);
  localparam int CNT_W = cnt_width(GAP_CYCLES, START_TIMEOUT);
  localparam logic [31:0] TIMEOUT_LIM = 32'(START_TIMEOUT);
  localparam logic [31:0] GAP_LIM     = 32'(GAP_CYCLES);

  state_t             state_r, state_nx;
  logic [NUM_REQ-1:0] grant_r, grant_nx, pick;
  logic [IDX_W-1:0]   last_grant_r, last_grant_nx;
  logic [CNT_W-1:0]   cnt_r, cnt_nx;
  logic [7:0]         tx_data_r, tx_data_nx, sel_data;
  logic               last_r, last_nx, sel_last, sel_valid;
  logic               tx_wr_r, busy_r;
  logic               timeout_hit, gap_done;

  uart_tx_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req        (req_valid),
    .last_grant (last_grant_r),
    .grant      (pick)
  );

  // Byte, last flag and valid of the current owner.
  always_comb begin
    sel_data = 8'h00;
    sel_last = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_data = sel_data | (req_data[8*i +: 8] & {8{grant_r[i]}});
      sel_last = sel_last | (req_last[i] & grant_r[i]);
    end
    sel_valid = |(req_valid & grant_r);
  end

  // A zero limit behaves like one: the state is left after a single cycle.
  assign timeout_hit = (32'(cnt_r) + 32'd1) >= TIMEOUT_LIM;
  assign gap_done    = (32'(cnt_r) + 32'd1) >= GAP_LIM;

  // Next-state logic; the counter restarts at zero whenever it is not held.
  always_comb begin
    state_nx      = state_r;
    grant_nx      = grant_r;
    last_grant_nx = last_grant_r;
    cnt_nx        = '0;
    tx_data_nx    = tx_data_r;
    last_nx       = last_r;
    case (state_r)
      ST_IDLE: begin
        if (|req_valid) begin
          grant_nx = pick;
          state_nx = ST_LOAD;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (sel_valid) begin
          tx_data_nx = sel_data;
          last_nx    = sel_last;
          state_nx   = ST_STROBE;
        end else begin
          state_nx = ST_LOAD;
        end
      end
      ST_STROBE: begin
        state_nx = ST_WAIT_START;
      end
      ST_WAIT_START: begin
        // A transmitter that never drops idle still releases the byte.
        if (!tx_idle || timeout_hit) begin
          state_nx = ST_WAIT_DONE;
        end else begin
          cnt_nx = cnt_r + CNT_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (tx_idle) begin
          state_nx = last_r ? ST_GAP : ST_LOAD;
        end else begin
          state_nx = ST_WAIT_DONE;
        end
      end
      ST_GAP: begin
        if (gap_done) begin
          grant_nx      = '0;
          last_grant_nx = IDX_W'(onehot_idx(8'(grant_r)));
          state_nx      = ST_IDLE;
        end else begin
          cnt_nx = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_nx = ST_IDLE;
        grant_nx = '0;
      end
    endcase
  end

  // State and output registers; tx_wr and busy are registered decodes of the next state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      grant_r      <= '0;
      last_grant_r <= IDX_W'(NUM_REQ - 1);
      cnt_r        <= '0;
      tx_data_r    <= 8'h00;
      last_r       <= 1'b0;
      tx_wr_r      <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_nx;
      grant_r      <= grant_nx;
      last_grant_r <= last_grant_nx;
      cnt_r        <= cnt_nx;
      tx_data_r    <= tx_data_nx;
      last_r       <= last_nx;
      tx_wr_r      <= (state_nx == ST_STROBE);
      busy_r       <= (state_nx != ST_IDLE);
    end
  end

  assign req_ready = (state_r == ST_LOAD) ? (grant_r & req_valid) : '0;
  assign tx_data   = tx_data_r;
  assign tx_wr     = tx_wr_r;
  assign grant     = grant_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: queue-driven requesters and a
// transmitter model whose idle drops for 10 cycles after each write.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  req_valid = 4'h0;
  logic [31:0] req_data = 32'h0;
  logic [3:0]  req_last = 4'h0;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_wr;
  logic        tx_idle = 1'b1;
  logic [3:0]  grant;
  logic        busy;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ       (4),
    .GAP_CYCLES    (16),
    .START_TIMEOUT (15)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_data   (tx_data),
    .tx_wr     (tx_wr),
    .tx_idle   (tx_idle),
    .grant     (grant),
    .busy      (busy)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic [8:0] q [4][$];
  int tx_cnt = 0;
  bit force_idle = 1'b0;
  int stall_left = 0;
  int stall_after = -1;
  int hs0_count = 0;
  int onehot_viol = 0;
  int stall_grant_bad = 0;
  logic [7:0] wr_byte [$];
  logic [3:0] wr_grant [$];
  int wr_cyc [$];
  int hs_cyc [$];
  logic [3:0] hs_vec [$];
  int w0, nwr;
  logic [7:0] exp_b;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input int id, input logic [7:0] b, input logic last);
    q[id].push_back({last, b});
  endtask

  // One clock: observe outputs, run the transmitter model, drive requesters,
  // then sample the handshake that the coming rising edge will take.
  task automatic cycle();
    logic [8:0] head;
    @(negedge clk);
    cyc++;
    if ((grant & (grant - 4'd1)) != 4'd0) onehot_viol++;
    if (stall_left > 0 && grant != 4'b0001) stall_grant_bad++;
    if (tx_wr === 1'b1) begin
      wr_byte.push_back(tx_data);
      wr_grant.push_back(grant);
      wr_cyc.push_back(cyc);
    end
    tx_idle = force_idle || (tx_cnt == 0);
    if (tx_wr === 1'b1) tx_cnt = 10;
    else if (tx_cnt > 0) tx_cnt--;
    for (int i = 0; i < 4; i++) begin
      if (q[i].size() > 0) head = q[i][0];
      else head = 9'h000;
      req_valid[i] = (q[i].size() > 0) && !(i == 0 && stall_left > 0);
      req_data[8*i +: 8] = head[7:0];
      req_last[i] = head[8];
    end
    if (stall_left > 0) stall_left--;
    #1;
    if (req_ready != 4'd0) begin
      hs_cyc.push_back(cyc);
      hs_vec.push_back(req_ready);
      for (int i = 0; i < 4; i++) begin
        if (req_ready[i] && q[i].size() > 0) void'(q[i].pop_front());
      end
      if (req_ready[0]) begin
        hs0_count++;
        if (hs0_count == stall_after) stall_left = 50;
      end
    end
  endtask

  task automatic run_to(input int target);
    while (cyc < target) cycle();
  endtask

  task automatic wait_wr(input int n, input int budget, input string tag);
    int t0;
    t0 = cyc;
    while (wr_byte.size() < n && (cyc - t0) < budget) cycle();
    check_eq(tag, wr_byte.size(), n);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 4; i++) q[i].delete();
    stall_left = 0;
    stall_after = -1;
    hs0_count = 0;
    force_idle = 1'b0;
    tx_cnt = 0;
    repeat (3) cycle();
    reset_n = 1'b1;
    wr_byte.delete();
    wr_grant.delete();
    wr_cyc.delete();
    hs_cyc.delete();
    hs_vec.delete();
    onehot_viol = 0;
    stall_grant_bad = 0;
  endtask

  initial begin
    // Reset state and a single three-byte frame from requester 0.
    do_reset();
    cycle();
    check_eq("rst_grant", grant, 4'h0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_tx_wr", tx_wr, 1'b0);
    check_eq("rst_tx_data", tx_data, 8'h00);
    check_eq("rst_req_ready", req_ready, 4'h0);

    push(0, 8'h41, 1'b0);
    push(0, 8'h44, 1'b0);
    push(0, 8'h0D, 1'b1);
    wait_wr(3, 200, "single_wr_count");
    check_eq("single_hs_count", hs_cyc.size(), 3);
    check_eq("single_b0", wr_byte[0], 8'h41);
    check_eq("single_b1", wr_byte[1], 8'h44);
    check_eq("single_b2", wr_byte[2], 8'h0D);
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("single_hs_owner%0d", k), hs_vec[k], 4'b0001);
      check_eq($sformatf("single_latency%0d", k), wr_cyc[k] - hs_cyc[k], 1);
      check_eq($sformatf("single_grant%0d", k), wr_grant[k], 4'b0001);
    end
    // wr, 1 WAIT_START, 10 idle-low cycles, then LOAD and STROBE again.
    check_eq("single_spacing", wr_cyc[1] - wr_cyc[0], 13);
    w0 = wr_cyc[2];
    push(0, 8'h5A, 1'b1);
    // Last byte: WAIT_DONE ends at +11, GAP spans +12..+27, IDLE at +28.
    run_to(w0 + 27);
    check_eq("gap_grant_held", grant, 4'b0001);
    check_eq("gap_busy", busy, 1'b1);
    run_to(w0 + 28);
    check_eq("gap_grant_cleared", grant, 4'h0);
    check_eq("gap_busy_low", busy, 1'b0);
    run_to(w0 + 29);
    check_eq("regrant_same", grant, 4'b0001);
    wait_wr(4, 100, "regrant_wr_count");
    check_eq("regrant_wr_time", wr_cyc[3] - w0, 30);
    check_eq("regrant_byte", wr_byte[3], 8'h5A);

    // Contention: all four requesters with two-byte frames.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push(i, 8'hA0 + 8'(i), 1'b0);
      push(i, 8'hB0 + 8'(i), 1'b1);
    end
    wait_wr(8, 600, "contend_wr_count");
    for (int k = 0; k < 8; k++) begin
      exp_b = ((k % 2) == 1) ? 8'hB0 : 8'hA0;
      exp_b = exp_b + 8'(k / 2);
      check_eq($sformatf("contend_grant%0d", k), wr_grant[k], 4'b0001 << (k / 2));
      check_eq($sformatf("contend_byte%0d", k), wr_byte[k], exp_b);
    end
    check_eq("contend_onehot", onehot_viol, 0);

    // Fairness: requester 1 always pending, requester 2 once.
    do_reset();
    push(1, 8'h11, 1'b1);
    push(1, 8'h12, 1'b1);
    push(1, 8'h13, 1'b1);
    push(2, 8'h21, 1'b1);
    wait_wr(3, 300, "fair_wr_count");
    check_eq("fair_grant0", wr_grant[0], 4'b0010);
    check_eq("fair_grant1", wr_grant[1], 4'b0100);
    check_eq("fair_grant2", wr_grant[2], 4'b0010);
    check_eq("fair_byte1", wr_byte[1], 8'h21);
    check_eq("fair_byte2", wr_byte[2], 8'h12);

    // Timeout: idle never drops; 15 WAIT_START + WAIT_DONE + LOAD + STROBE.
    do_reset();
    force_idle = 1'b1;
    push(0, 8'h31, 1'b0);
    push(0, 8'h32, 1'b0);
    push(0, 8'h33, 1'b1);
    wait_wr(3, 200, "timeout_wr_count");
    check_eq("timeout_spacing0", wr_cyc[1] - wr_cyc[0], 18);
    check_eq("timeout_spacing1", wr_cyc[2] - wr_cyc[1], 18);
    w0 = wr_cyc[2];
    run_to(w0 + 32);
    check_eq("timeout_gap_held", grant, 4'b0001);
    run_to(w0 + 33);
    check_eq("timeout_released", grant, 4'h0);

    // Stall: requester 0 drops valid for 50 cycles after its second byte.
    do_reset();
    stall_after = 2;
    push(0, 8'h61, 1'b0);
    push(0, 8'h62, 1'b0);
    push(0, 8'h63, 1'b0);
    push(0, 8'h64, 1'b1);
    wait_wr(4, 400, "stall_wr_count");
    check_eq("stall_spacing", wr_cyc[2] - wr_cyc[1], 51);
    check_eq("stall_grant_kept", stall_grant_bad, 0);
    check_eq("stall_byte2", wr_byte[2], 8'h63);
    check_eq("stall_byte3", wr_byte[3], 8'h64);

    // Reset during WAIT_DONE of byte 2 of 3.
    do_reset();
    push(0, 8'h71, 1'b0);
    push(0, 8'h72, 1'b0);
    push(0, 8'h73, 1'b1);
    wait_wr(2, 200, "rstmid_wr_count");
    run_to(wr_cyc[1] + 4);
    reset_n = 1'b0;
    cycle();
    check_eq("rstmid_grant", grant, 4'h0);
    check_eq("rstmid_busy", busy, 1'b0);
    check_eq("rstmid_tx_wr", tx_wr, 1'b0);
    check_eq("rstmid_tx_data", tx_data, 8'h00);
    check_eq("rstmid_req_ready", req_ready, 4'h0);
    cycle();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) q[i].delete();
    nwr = wr_byte.size();
    repeat (20) cycle();
    check_eq("rstmid_no_wr", wr_byte.size(), nwr);
    push(3, 8'h82, 1'b1);
    push(0, 8'h81, 1'b1);
    wait_wr(nwr + 1, 100, "rstmid_fresh_count");
    check_eq("rstmid_fresh_grant", wr_grant[nwr], 4'b0001);
    check_eq("rstmid_fresh_byte", wr_byte[nwr], 8'h81);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of byte-stream requesters (2..8).
REQ-002 Parameter GAP_CYCLES, default 16: idle clocks enforced between frames (0 allowed).
REQ-003 Parameter START_TIMEOUT, default 15: maximum clocks to wait for tx_idle to fall after tx_wr.
REQ-004 clk  input  1  system clock; all logic rising-edge.
REQ-005 reset_n  input  1  reset, synchronous, active-low.
REQ-006 req_valid  input  NUM_REQ  per-requester byte available.
REQ-007 req_data  input  8*NUM_REQ  per-requester byte; requester i occupies bits [8i+7:8i].
REQ-008 req_last  input  NUM_REQ  qualifies the current byte as the final byte of a frame.
REQ-009 req_ready  output  NUM_REQ  byte accepted from requester i this cycle.
REQ-010 tx_data  output  8  byte to the UART transmitter datain.
REQ-011 tx_wr  output  1  single-cycle write strobe to the transmitter wrsig.
REQ-012 tx_idle  input  1  transmitter idle; high when not shifting.
REQ-013 grant  output  NUM_REQ  one-hot owner of the transmitter; all-zero when unowned.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 FSM states: IDLE, LOAD, STROBE, WAIT_START, WAIT_DONE, GAP.
REQ-016 IDLE: if any req_valid is high, grant the first valid requester found searching upward from (last_grant+1) mod NUM_REQ, then go to LOAD; otherwise remain in IDLE.
REQ-017 Grant changes only in IDLE and is held for the whole frame, through the byte with req_last set.
REQ-018 LOAD: req_ready[i] = (state==LOAD) & grant[i] & req_valid[i], combinational; all other req_ready bits are 0.
REQ-019 On the LOAD handshake, register tx_data and the last flag, then go to STROBE.
REQ-020 If the granted requester's req_valid is low in LOAD, wait indefinitely; grant is kept.
REQ-021 STROBE: tx_wr=1 for exactly one cycle, with tx_data stable; go to WAIT_START.
REQ-022 WAIT_START: go to WAIT_DONE when tx_idle==0, or after START_TIMEOUT cycles (byte counted as sent).
REQ-023 WAIT_DONE: when tx_idle==1, go to GAP if the stored last flag is 1, else return to LOAD.
REQ-024 GAP: count GAP_CYCLES clocks, then clear grant, update last_grant and go to IDLE; GAP_CYCLES=0 goes to IDLE on the next clock.
REQ-025 tx_data holds its value outside STROBE; it changes only on the LOAD handshake.
REQ-026 Simultaneous valid requesters: strict round-robin, with no requester served twice while another waits.
REQ-027 A single active requester is re-granted immediately after its GAP.
REQ-028 Byte-to-byte latency: LOAD handshake to tx_wr = 1 cycle.

Reset
REQ-029 While reset_n is low at a clock edge, set: state=IDLE, grant=0, req_ready=0, tx_wr=0, tx_data=8'h00, busy=0, counters=0, last_grant=NUM_REQ-1 (so requester 0 has first priority).
REQ-030 Reset mid-frame abandons the frame without emitting a further tx_wr; the requester must restart its frame.

Structure
REQ-031 A shared package holds the FSM state encoding and the localparam widths derived from NUM_REQ, GAP_CYCLES and START_TIMEOUT (clog2).
REQ-032 The round-robin priority search is one sub-module, rr_pick (inputs: request vector, last grant; output: one-hot grant), combinational.
REQ-033 The transmitter and clock divider are outside this block; tx_data, tx_wr and tx_idle connect directly to the transmitter's datain, wrsig and idle.

Verification
REQ-034 Single frame: req0 sends 8'h41, 8'h44, 8'h0D (last on 8'h0D), with a transmitter model idle-low for 10 cycles after each wr -> exactly 3 tx_wr pulses carrying those bytes in order, each preceded by one req_ready[0], then GAP 16 cycles, grant returns to 0.
REQ-035 Contention: req0..req3 all valid at once, each with a 2-byte frame -> frames are sent in order 0,1,2,3 with no byte interleaving, and grant stays one-hot throughout.
REQ-036 Fairness: req1 continuously re-requests while req2 requests once -> order 1,2,1; req1 is not served twice in a row.
REQ-037 Timeout: tx_idle held high always -> each byte advances after 15 WAIT_START cycles plus one, with no hang.
REQ-038 Stall: req0 deasserts req_valid for 50 cycles mid-frame -> grant stays on 0 and no tx_wr is issued, then the frame resumes.
REQ-039 Reset in WAIT_DONE of byte 2 of 3 -> next cycle all outputs are at reset values, no tx_wr follows, and a fresh request is granted to requester 0 first.
